// File: rtl/lockpick_session_arbiter_pkg.sv
// Shared types and constants for the lockpick session arbiter.
package lockpick_pkg;

    typedef enum logic [2:0] {
        ARB,
        START,
        FEED,
        WAIT_OUT,
        DRAIN,
        DONE
    } arb_state_t;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ERR  = 2'b01;
    localparam logic [1:0] ST_WIN  = 2'b10;
    localparam logic [1:0] ST_LOCK = 2'b11;

    localparam int KEY_BYTES = 32;
    localparam int MSG_BYTES = 32;

endpackage

// File: rtl/lockpick_session_arbiter_if.sv
// Player-side and core-side signal bundle; slave = arbiter, master = players/core.
interface lockpick_session_arbiter_if #(
    parameter int N_PLAYERS = 4,
    parameter int ID_W      = $clog2(N_PLAYERS)
);
    logic [N_PLAYERS-1:0]      p_req;
    logic [N_PLAYERS-1:0]      p_in_valid;
    logic [N_PLAYERS-1:0][7:0] p_in_data;
    logic [N_PLAYERS-1:0]      p_in_ready;
    logic [N_PLAYERS-1:0]      grant;
    logic                      resp_valid;
    logic [7:0]                resp_data;
    logic [ID_W-1:0]           resp_id;
    logic [1:0]                resp_status;
    logic                      session_done;
    logic                      core_start;
    logic                      core_input_enable;
    logic [7:0]                core_input_data;
    logic                      core_output_valid;
    logic [7:0]                core_output_data;
    logic [1:0]                core_status;
    logic                      core_rst_n;

    modport slave (
        input  p_req, p_in_valid, p_in_data, core_output_valid, core_output_data, core_status,
        output p_in_ready, grant, resp_valid, resp_data, resp_id, resp_status, session_done,
               core_start, core_input_enable, core_input_data, core_rst_n
    );

    modport master (
        output p_req, p_in_valid, p_in_data, core_output_valid, core_output_data, core_status,
        input  p_in_ready, grant, resp_valid, resp_data, resp_id, resp_status, session_done,
               core_start, core_input_enable, core_input_data, core_rst_n
    );
endinterface

// File: rtl/lockpick_session_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] id_o
);
    logic [W-1:0] idx;

    // Scan farthest-first so the hit closest to the pointer is written last.
    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = W'((int'(ptr_i) + k) % N);
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                id_o       = idx;
            end
        end
    end
endmodule

// File: rtl/lockpick_session_arbiter.sv
// Session arbiter sharing one lockpick core among N_PLAYERS requesters.
// Optional idle-input timeout enabled by defining LOCKPICK_ARB_TIMEOUT_EN.
module lockpick_session_arbiter
    import lockpick_pkg::*;
#(
    parameter int N_PLAYERS      = 4,
    parameter int ID_W           = $clog2(N_PLAYERS),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                      clk,
    input logic                      rst,
    lockpick_session_arbiter_if.slave bus
);
    arb_state_t           state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      resp_id_q, resp_id_d;
    logic [N_PLAYERS-1:0] grant_q, grant_d;
    logic [5:0]           byte_cnt_q, byte_cnt_d;
    logic [4:0]           out_cnt_q, out_cnt_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [7:0]           resp_data_q, resp_data_d;
    logic [1:0]           resp_status_q, resp_status_d;

    logic [N_PLAYERS-1:0] arb_gnt, ready;
    logic [ID_W-1:0]      arb_id, ptr_next;
    logic                 accept, in_en, start, done;
    logic [7:0]           in_data;

`ifdef LOCKPICK_ARB_TIMEOUT_EN
    logic [15:0] idle_q, idle_d;
    logic [1:0]  hold_q, hold_d;
`endif

    rr_arbiter #(.N(N_PLAYERS), .W(ID_W)) u_rr (
        .req_i (bus.p_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .id_o  (arb_id)
    );

    assign ptr_next = (resp_id_q == ID_W'(N_PLAYERS - 1)) ? '0 : resp_id_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        resp_id_d     = resp_id_q;
        grant_d       = grant_q;
        byte_cnt_d    = byte_cnt_q;
        out_cnt_d     = out_cnt_q;
        resp_valid_d  = 1'b0;
        resp_data_d   = resp_data_q;
        resp_status_d = resp_status_q;
        ready         = '0;
        in_en         = 1'b0;
        in_data       = '0;
        start         = 1'b0;
        done          = 1'b0;
        accept        = 1'b0;
        case (state_q)
            ARB: begin
                if (|arb_gnt) begin
                    grant_d   = arb_gnt;
                    resp_id_d = arb_id;
                    state_d   = START;
                end
            end
            START: begin
                start      = 1'b1;
                byte_cnt_d = '0;
                state_d    = FEED;
            end
            FEED: begin
                ready[resp_id_q] = 1'b1;
                in_en            = bus.p_in_valid[resp_id_q];
                in_data          = bus.p_in_data[resp_id_q];
                accept           = in_en;
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 6'(2 * KEY_BYTES - 1)) begin
                        out_cnt_d = '0;
                        state_d   = WAIT_OUT;
                    end
                end
            end
            // The byte that wakes WAIT_OUT is the first result byte, so it is captured too.
            WAIT_OUT, DRAIN: begin
                if (bus.core_output_valid) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = bus.core_output_data;
                    out_cnt_d    = out_cnt_q + 1'b1;
                    state_d      = DRAIN;
                    if (state_q == DRAIN && out_cnt_q == 5'(MSG_BYTES - 1)) begin
                        resp_status_d = bus.core_status;
                        if (bus.core_status == ST_ERR) begin
                            byte_cnt_d = '0;
                            state_d    = FEED;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                grant_d  = '0;
                rr_ptr_d = ptr_next;
                state_d  = ARB;
            end
            default: state_d = ARB;
        endcase

`ifdef LOCKPICK_ARB_TIMEOUT_EN
        idle_d = '0;
        hold_d = (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
        if (state_q == FEED && !accept) begin
            idle_d = idle_q + 16'd1;
            if (idle_q == 16'(TIMEOUT_CYCLES - 1)) begin
                hold_d        = 2'd2;
                resp_status_d = ST_LOCK;
                state_d       = DONE;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ARB;
            rr_ptr_q      <= '0;
            resp_id_q     <= '0;
            grant_q       <= '0;
            byte_cnt_q    <= '0;
            out_cnt_q     <= '0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
            resp_status_q <= '0;
`ifdef LOCKPICK_ARB_TIMEOUT_EN
            idle_q        <= '0;
            hold_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            resp_id_q     <= resp_id_d;
            grant_q       <= grant_d;
            byte_cnt_q    <= byte_cnt_d;
            out_cnt_q     <= out_cnt_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            resp_status_q <= resp_status_d;
`ifdef LOCKPICK_ARB_TIMEOUT_EN
            idle_q        <= idle_d;
            hold_q        <= hold_d;
`endif
        end
    end

    assign bus.grant             = grant_q;
    assign bus.p_in_ready        = ready;
    assign bus.resp_valid        = resp_valid_q;
    assign bus.resp_data         = resp_data_q;
    assign bus.resp_id           = resp_id_q;
    assign bus.resp_status       = resp_status_q;
    assign bus.session_done      = done;
    assign bus.core_start        = start;
    assign bus.core_input_enable = in_en;
    assign bus.core_input_data   = in_data;
`ifdef LOCKPICK_ARB_TIMEOUT_EN
    assign bus.core_rst_n        = (hold_q == 2'd0);
`else
    assign bus.core_rst_n        = 1'b1;
`endif

endmodule

// File: tb/tb_lockpick_session_arbiter.sv
// Directed bench: session table plus hand-written contention, reset and timeout sequences.
module tb_lockpick_session_arbiter;
    import lockpick_pkg::*;

    localparam int NP   = 4;
    localparam int TOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lockpick_session_arbiter_if #(.N_PLAYERS(NP)) bus();

    lockpick_session_arbiter #(.N_PLAYERS(NP), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Core model: 64 input beats, short delay, then 32 result bytes with status.
    logic [1:0] sts_tab [3];
    int beats_m, attempt_m, dly_m, outk_m;
    bit emit_m;

    function automatic logic [7:0] mdata(input logic [1:0] st, input int k);
        if (st == ST_WIN)  return (k % 2 == 0) ? 8'hCE : 8'hFA;
        if (st == ST_LOCK) return (k % 2 == 0) ? 8'hAD : 8'hDE;
        return 8'(8'h40 + k);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst || !bus.core_rst_n) begin
            beats_m <= 0; attempt_m <= 0; dly_m <= 0; outk_m <= 0; emit_m <= 1'b0;
            bus.core_output_valid <= 1'b0;
            bus.core_output_data  <= '0;
            bus.core_status       <= '0;
        end else begin
            bus.core_output_valid <= 1'b0;
            if (bus.core_start) begin
                attempt_m <= 0;
                beats_m   <= 0;
            end
            if (!emit_m) begin
                if (bus.core_input_enable) begin
                    if (beats_m == 63) begin
                        beats_m <= 0; emit_m <= 1'b1; dly_m <= 3; outk_m <= 0;
                    end else begin
                        beats_m <= beats_m + 1;
                    end
                end
            end else if (dly_m > 0) begin
                dly_m <= dly_m - 1;
            end else begin
                bus.core_output_valid <= 1'b1;
                bus.core_output_data  <= mdata(sts_tab[attempt_m > 2 ? 2 : attempt_m], outk_m);
                bus.core_status       <= sts_tab[attempt_m > 2 ? 2 : attempt_m];
                outk_m <= outk_m + 1;
                if (outk_m == 31) begin
                    emit_m    <= 1'b0;
                    attempt_m <= attempt_m + 1;
                end
            end
        end
    end

    // Monitor, sampled on the falling edge.
    int n_start = 0, n_beats = 0, n_done = 0, n_bad_en = 0, n_crst_low = 0, fed = 0;
    logic [7:0]    resp_q [$];
    logic [NP-1:0] glog [$];
    logic [NP-1:0] gprev = '0;

    always @(negedge clk) begin
        if (bus.core_start)      n_start++;
        if (bus.core_input_enable) n_beats++;
        if (bus.session_done)    n_done++;
        if (!bus.core_rst_n)     n_crst_low++;
        if (bus.resp_valid)      resp_q.push_back(bus.resp_data);
        if (bus.grant != '0 && bus.grant != gprev) glog.push_back(bus.grant);
        gprev = bus.grant;
        if (|(bus.p_in_ready & bus.p_in_valid)) fed++;
        if (bus.core_input_enable !== (|(bus.grant & bus.p_in_ready & bus.p_in_valid))) n_bad_en++;
        if ($countones(bus.p_in_ready) > 1) n_bad_en++;
    end

    // Player driver: owner streams bytes (optionally throttled / stalled), others make noise.
    bit throttle = 1'b0, noise = 1'b0, tog = 1'b0;
    int stall_after = -1, fed_base = 0;

    always @(posedge clk) begin
        #1;
        tog = ~tog;
        for (int i = 0; i < NP; i++) begin
            if (bus.grant[i]) begin
                bus.p_in_valid[i] = !throttle || tog;
                if (stall_after >= 0 && (fed - fed_base) >= stall_after) bus.p_in_valid[i] = 1'b0;
                bus.p_in_data[i] = 8'(fed);
            end else begin
                bus.p_in_valid[i] = noise;
                bus.p_in_data[i]  = 8'hEE;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(input int g0, input string nm, output logic [NP-1:0] g);
        int t = 0;
        while (glog.size() <= g0 && t < 200) begin tick(); t++; end
        chk(nm, int'(glog.size() > g0), 1);
        g = (glog.size() > g0) ? glog[g0] : '0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        int t = 0;
        while (n_done <= d0 && t < 3000) begin tick(); t++; end
        chk(nm, int'(n_done > d0), 1);
    endtask

    typedef struct {
        logic [NP-1:0] req;
        logic [1:0]    s0, s1, s2;
        bit            thr;
        logic [NP-1:0] g;
        int            rid, starts, beats, nbytes;
        logic [1:0]    st;
        logic [7:0]    first, pa, pb;
    } vec_t;

    vec_t tv [4];

    initial begin
        logic [NP-1:0] g;
        int s0, b0, r0, d0, g0, f0, c0, t;

        tv[0] = '{4'b0001, ST_WIN,  ST_WIN,  ST_WIN,  1'b0, 4'b0001, 0, 1,  64, 32, ST_WIN,  8'hCE, 8'hCE, 8'hFA};
        tv[1] = '{4'b0100, ST_ERR,  ST_ERR,  ST_LOCK, 1'b0, 4'b0100, 2, 1, 192, 96, ST_LOCK, 8'h40, 8'hAD, 8'hDE};
        tv[2] = '{4'b0010, ST_WIN,  ST_WIN,  ST_WIN,  1'b1, 4'b0010, 1, 1,  64, 32, ST_WIN,  8'hCE, 8'hCE, 8'hFA};
        tv[3] = '{4'b1000, ST_IDLE, ST_IDLE, ST_IDLE, 1'b0, 4'b1000, 3, 1,  64, 32, ST_IDLE, 8'h40, 8'h40, 8'h41};

        bus.p_req = '0;
        bus.p_in_valid = '0;
        bus.p_in_data = '0;
        sts_tab[0] = ST_WIN; sts_tab[1] = ST_WIN; sts_tab[2] = ST_WIN;
        repeat (3) tick();
        chk("reset_grant",   int'(bus.grant), 0);
        chk("reset_outputs", int'({bus.resp_valid, bus.session_done, bus.core_start,
                                   bus.core_input_enable, bus.p_in_ready, bus.resp_status}), 0);
        chk("reset_core_rst_n", int'(bus.core_rst_n), 1);
        rst = 1'b1;
        tick();

        foreach (tv[i]) begin
            sts_tab[0] = tv[i].s0; sts_tab[1] = tv[i].s1; sts_tab[2] = tv[i].s2;
            throttle = tv[i].thr; noise = tv[i].thr;
            s0 = n_start; b0 = n_beats; r0 = resp_q.size(); d0 = n_done; g0 = glog.size(); f0 = fed;
            bus.p_req = tv[i].req;
            wait_grant(g0, $sformatf("v%0d_grant_seen", i), g);
            chk($sformatf("v%0d_grant", i), int'(g), int'(tv[i].g));
            chk($sformatf("v%0d_resp_id", i), int'(bus.resp_id), tv[i].rid);
            bus.p_req = '0;
            wait_done(d0, $sformatf("v%0d_done", i));
            chk($sformatf("v%0d_starts", i), n_start - s0, tv[i].starts);
            chk($sformatf("v%0d_beats", i), n_beats - b0, tv[i].beats);
            chk($sformatf("v%0d_accepts", i), fed - f0, tv[i].beats);
            chk($sformatf("v%0d_nbytes", i), resp_q.size() - r0, tv[i].nbytes);
            chk($sformatf("v%0d_first", i), int'(resp_q[r0]), int'(tv[i].first));
            chk($sformatf("v%0d_last_pair", i),
                int'({resp_q[r0 + tv[i].nbytes - 32], resp_q[r0 + tv[i].nbytes - 31]}),
                int'({tv[i].pa, tv[i].pb}));
            chk($sformatf("v%0d_status", i), int'(bus.resp_status), int'(tv[i].st));
            tick();
            chk($sformatf("v%0d_released", i), int'(bus.grant), 0);
            chk($sformatf("v%0d_bad_en", i), n_bad_en, 0);
        end
        throttle = 1'b0; noise = 1'b0;
        sts_tab[0] = ST_WIN; sts_tab[1] = ST_WIN; sts_tab[2] = ST_WIN;

        // Contention: three requesters held, pointer starts at 0.
        g0 = glog.size(); d0 = n_done;
        bus.p_req = 4'b1011;
        t = 0;
        while (glog.size() < g0 + 3 && t < 2000) begin tick(); t++; end
        bus.p_req = '0;
        chk("rr_three_grants", int'(glog.size() >= g0 + 3), 1);
        chk("rr_order", int'({glog[g0], glog[g0 + 1], glog[g0 + 2]}), int'({4'b0001, 4'b0010, 4'b1000}));
        t = 0;
        while (n_done < d0 + 3 && t < 2000) begin tick(); t++; end
        chk("rr_three_done", n_done - d0, 3);

        // Player 2 leaves the pointer at 3; all-request then grants player 3 first.
        g0 = glog.size(); d0 = n_done;
        bus.p_req = 4'b0100;
        wait_grant(g0, "p2_grant_seen", g);
        bus.p_req = '0;
        wait_done(d0, "p2_done");
        tick();
        g0 = glog.size(); d0 = n_done;
        bus.p_req = 4'b1111;
        wait_grant(g0, "ptr3_grant_seen", g);
        chk("ptr3_grant", int'(g), 4'b1000);
        bus.p_req = '0;
        wait_done(d0, "ptr3_done");
        tick();

        // Leave pointer at 2, then reset in the middle of the next result stream.
        g0 = glog.size(); d0 = n_done;
        bus.p_req = 4'b0010;
        wait_grant(g0, "pre_rst_grant_seen", g);
        bus.p_req = '0;
        wait_done(d0, "pre_rst_done");
        tick();
        g0 = glog.size(); r0 = resp_q.size();
        bus.p_req = 4'b0010;
        wait_grant(g0, "mid_grant_seen", g);
        bus.p_req = '0;
        t = 0;
        while (resp_q.size() < r0 + 10 && t < 2000) begin tick(); t++; end
        chk("mid_drain_reached", int'(resp_q.size() >= r0 + 10), 1);
        rst = 1'b0;
        #1;
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_outputs", int'({bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_status, bus.session_done,
                                 bus.core_start, bus.core_input_enable, bus.core_input_data, bus.p_in_ready}), 0);
        chk("rst_core_rst_n", int'(bus.core_rst_n), 1);
        tick(); tick();
        rst = 1'b1;
        tick();
        g0 = glog.size(); d0 = n_done;
        bus.p_req = 4'b1111;
        wait_grant(g0, "post_rst_grant_seen", g);
        chk("post_rst_grant", int'(g), 4'b0001);
        bus.p_req = '0;
        wait_done(d0, "post_rst_done");
        tick();

`ifdef LOCKPICK_ARB_TIMEOUT_EN
        // Pointer is 1: player 1 is granted, stalls after 6 bytes and times out.
        g0 = glog.size(); d0 = n_done; c0 = n_crst_low; b0 = n_beats;
        fed_base = fed; stall_after = 6;
        bus.p_req = 4'b0011;
        wait_grant(g0, "to_grant_seen", g);
        chk("to_first_grant", int'(g), 4'b0010);
        wait_grant(g0 + 1, "to_next_grant_seen", g);
        stall_after = -1;
        bus.p_req = '0;
        chk("to_next_grant", int'(g), 4'b0001);
        chk("to_stalled_beats", n_beats - b0, 6);
        chk("to_core_rst_cycles", n_crst_low - c0, 2);
        chk("to_status", int'(bus.resp_status), int'(ST_LOCK));
        chk("to_done", n_done - d0, 1);
        wait_done(d0 + 1, "to_next_done");
        chk("to_next_status", int'(bus.resp_status), int'(ST_WIN));
`else
        c0 = n_crst_low;
        chk("no_core_rst", c0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
